// File: rtl/ecc_secded_decode_pipe_if.sv
// Codeword/result stream bundle for the SECDED decode pipe.
// The slave side is the decoder; the master side feeds codewords and consumes results.
interface ecc_secded_decode_pipe_if #(
    parameter int DATA_W = 32
);
    function automatic int calc_par_w(input int dw);
        int p;
        p = 0;
        for (int q = 1; q < 8; q++) begin
            if (p == 0 && (1 << q) >= dw + q + 1) p = q;
        end
        return p;
    endfunction

    localparam int PAR_W = calc_par_w(DATA_W);
    localparam int CW_W  = DATA_W + PAR_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   in_cw;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sec;
    logic              out_ded;
    logic [PAR_W-1:0]  out_syndrome;

    modport slave (
        input  in_valid, in_cw, out_ready,
        output in_ready, out_valid, out_data, out_sec, out_ded, out_syndrome
    );

    modport master (
        output in_valid, in_cw, out_ready,
        input  in_ready, out_valid, out_data, out_sec, out_ded, out_syndrome
    );
endinterface

// File: rtl/ecc_secded_decode_pipe.sv
// Two-stage SECDED decoder: stage 1 computes syndrome/parity, stage 2 corrects and flags.
// Both stages advance together under a single stall condition from the output side.
module ecc_secded_decode_pipe #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     correct_en,
    input  logic                     clr_counts,
    ecc_secded_decode_pipe_if.slave  bus,
    output logic [CNT_W-1:0]         sec_count,
    output logic [CNT_W-1:0]         ded_count
);
    function automatic int calc_par_w(input int dw);
        int p;
        p = 0;
        for (int q = 1; q < 8; q++) begin
            if (p == 0 && (1 << q) >= dw + q + 1) p = q;
        end
        return p;
    endfunction

    // Codeword index of payload bit j: the j-th non-power-of-two index from 1 up.
    function automatic int data_pos(input int j);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int i = 1; i < 128; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (n == j && pos == 0) pos = i;
                n++;
            end
        end
        return pos;
    endfunction

    localparam int PAR_W = calc_par_w(DATA_W);
    localparam int CW_W  = DATA_W + PAR_W + 1;
    localparam int SX_W  = PAR_W + 1;

    logic              advance;
    logic              out_fire;

    logic [PAR_W-1:0]  syn_c;
    logic              par_c;
    logic [DATA_W-1:0] raw_c;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_par;
    logic              s1_cen;

    logic              syn_in_range;
    logic              sec_c;
    logic              ded_c;
    logic              flip_en;
    logic [DATA_W-1:0] data_c;

    assign advance     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;
    assign out_fire    = bus.out_valid && bus.out_ready;

    always_comb begin
        syn_c = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (bus.in_cw[i]) syn_c ^= PAR_W'(i);
        end
    end

    assign par_c = ^bus.in_cw;

    // Syndrome may equal or exceed CW_W, which can need one more bit than PAR_W.
    assign syn_in_range = {1'b0, s1_syn} < SX_W'(CW_W);
    assign sec_c        = s1_par && syn_in_range;
    assign ded_c        = s1_par ? !syn_in_range : (s1_syn != '0);
    assign flip_en      = sec_c && s1_cen;

    for (genvar j = 0; j < DATA_W; j++) begin : g_bits
        localparam int POS = data_pos(j);
        assign raw_c[j]  = bus.in_cw[POS];
        assign data_c[j] = s1_data[j] ^ (flip_en && (s1_syn == PAR_W'(POS)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid         <= 1'b0;
            s1_data          <= '0;
            s1_syn           <= '0;
            s1_par           <= 1'b0;
            s1_cen           <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.out_data     <= '0;
            bus.out_sec      <= 1'b0;
            bus.out_ded      <= 1'b0;
            bus.out_syndrome <= '0;
        end else if (advance) begin
            s1_valid      <= bus.in_valid;
            bus.out_valid <= s1_valid;
            if (bus.in_valid) begin
                s1_data <= raw_c;
                s1_syn  <= syn_c;
                s1_par  <= par_c;
                s1_cen  <= correct_en;
            end
            if (s1_valid) begin
                bus.out_data     <= data_c;
                bus.out_sec      <= sec_c;
                bus.out_ded      <= ded_c;
                bus.out_syndrome <= s1_syn;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (clr_counts) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (out_fire) begin
            if (bus.out_sec && sec_count != '1) sec_count <= sec_count + CNT_W'(1);
            if (bus.out_ded && ded_count != '1) ded_count <= ded_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ecc_secded_decode_pipe.sv
// Bench for the SECDED decode pipe: directed cases plus randomized traffic against a
// codeword-level reference model; a 2-bit-counter twin shares the stimulus.
module tb_ecc_secded_decode_pipe;
    localparam int DATA_W = 32;
    localparam int PAR_W  = 6;
    localparam int CW_W   = 39;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sec;
        logic              ded;
        logic [PAR_W-1:0]  syn;
        int                cyc;
        int                stall_snap;
        bit                seen;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic correct_en = 1'b1;
    logic clr_counts = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [CW_W-1:0] in_cw = '0;
    logic [15:0] sec_a, ded_a;
    logic [1:0]  sec_b, ded_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_cnt = 0;
    bit stalled_prev = 0;
    bit last_in_hs = 0;
    bit use_dir = 0;
    exp_t dir_exp;
    exp_t exp_q[$];
    int m_sec16 = 0, m_ded16 = 0, m_sec2 = 0, m_ded2 = 0;

    ecc_secded_decode_pipe_if #(.DATA_W(DATA_W)) bus_a ();
    ecc_secded_decode_pipe_if #(.DATA_W(DATA_W)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_cw     = in_cw;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_cw     = in_cw;
    assign bus_b.out_ready = out_ready;

    ecc_secded_decode_pipe #(.DATA_W(DATA_W), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .correct_en(correct_en), .clr_counts(clr_counts),
        .bus(bus_a), .sec_count(sec_a), .ded_count(ded_a)
    );

    ecc_secded_decode_pipe #(.DATA_W(DATA_W), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .correct_en(correct_en), .clr_counts(clr_counts),
        .bus(bus_b), .sec_count(sec_b), .ded_count(ded_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        int k;
        int s;
        cw = '0;
        k = 0;
        s = 0;
        for (int i = 1; i < CW_W; i++) begin
            if ($countones(i) != 1) begin
                cw[i] = d[k];
                k++;
                if (cw[i]) s ^= i;
            end
        end
        for (int j = 0; j < PAR_W; j++) cw[1 << j] = s[j];
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic exp_t model(input logic [CW_W-1:0] cw, input logic cen);
        exp_t e;
        int s;
        int p;
        int k;
        logic [CW_W-1:0] f;
        s = 0;
        p = 0;
        k = 0;
        f = cw;
        for (int i = 0; i < CW_W; i++) begin
            if (cw[i]) begin
                p ^= 1;
                s ^= i;
            end
        end
        e.sec = 1'b0;
        e.ded = 1'b0;
        if (p == 1 && s < CW_W) begin
            e.sec = 1'b1;
            if (cen && s != 0) f[s] = ~f[s];
        end else if (p == 1 || s != 0) begin
            e.ded = 1'b1;
        end
        e.data = '0;
        for (int i = 1; i < CW_W; i++) begin
            if ($countones(i) != 1) begin
                e.data[k] = f[i];
                k++;
            end
        end
        e.syn = PAR_W'(s);
        e.cyc = 0;
        e.stall_snap = 0;
        e.seen = 0;
        return e;
    endfunction

    // One clock: judge handshakes from the settled pre-edge values, then cross the edge.
    task automatic cycle();
        exp_t e;
        bit in_hs;
        bit out_hs;
        #1;
        chk("in_ready", bus_a.in_ready, !bus_a.out_valid || out_ready);
        in_hs  = in_valid && bus_a.in_ready;
        out_hs = bus_a.out_valid && out_ready;
        if (stalled_prev) chk("hold_valid", bus_a.out_valid, 1);
        if (!bus_a.out_valid && exp_q.size() > 0 && stall_cnt == exp_q[0].stall_snap
            && cyc - exp_q[0].cyc >= 2)
            chk("late_valid", 0, 1);
        if (bus_a.out_valid || bus_b.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = exp_q[0];
                if (!e.seen && stall_cnt == e.stall_snap) chk("latency", cyc - e.cyc, 2);
                exp_q[0].seen = 1;
                chk("valid_b", bus_b.out_valid, 1);
                chk("data_a", bus_a.out_data, e.data);
                chk("sec_a", bus_a.out_sec, e.sec);
                chk("ded_a", bus_a.out_ded, e.ded);
                chk("syn_a", bus_a.out_syndrome, e.syn);
                chk("data_b", bus_b.out_data, e.data);
                chk("sec_b", bus_b.out_sec, e.sec);
                chk("ded_b", bus_b.out_ded, e.ded);
                if (out_hs) begin
                    void'(exp_q.pop_front());
                    if (!clr_counts) begin
                        if (e.sec && m_sec16 < 65535) m_sec16++;
                        if (e.ded && m_ded16 < 65535) m_ded16++;
                        if (e.sec && m_sec2 < 3) m_sec2++;
                        if (e.ded && m_ded2 < 3) m_ded2++;
                    end
                end
            end
        end
        if (clr_counts) begin
            m_sec16 = 0; m_ded16 = 0; m_sec2 = 0; m_ded2 = 0;
        end
        stalled_prev = bus_a.out_valid && !out_ready;
        if (stalled_prev) stall_cnt++;
        if (in_hs) begin
            e = use_dir ? dir_exp : model(in_cw, correct_en);
            e.cyc = cyc;
            e.stall_snap = stall_cnt;
            e.seen = 0;
            exp_q.push_back(e);
        end
        last_in_hs = in_hs;
        @(negedge clk);
        cyc++;
        chk("sec_count_a", sec_a, m_sec16);
        chk("ded_count_a", ded_a, m_ded16);
        chk("sec_count_b", sec_b, m_sec2);
        chk("ded_count_b", ded_b, m_ded2);
    endtask

    task automatic send(input logic [CW_W-1:0] cw);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_cw = cw;
        do begin
            cycle();
            n++;
        end while (!last_in_hs && n < 50);
        if (!last_in_hs) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_dir(input logic [CW_W-1:0] cw, input logic [DATA_W-1:0] d,
                            input logic sec, input logic ded, input logic [PAR_W-1:0] syn);
        dir_exp.data = d;
        dir_exp.sec = sec;
        dir_exp.ded = ded;
        dir_exp.syn = syn;
        use_dir = 1;
        send(cw);
        use_dir = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 40) begin
            cycle();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        cycle();
    endtask

    logic [31:0] clean_words [10] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h00000000,
        32'h12345678, 32'h87654321, 32'hDEADBEEF, 32'hCAFEBABE, 32'h0F0F0F0F, 32'hF0F0F0F0};

    initial begin
        logic [CW_W-1:0] cw;
        logic [CW_W-1:0] mask;
        logic [31:0] bp_words [4];
        int idx;
        int n;
        int pos;
        int nflip;

        #1;
        chk("rst_valid", bus_a.out_valid, 0);
        chk("rst_in_ready", bus_a.in_ready, 1);
        chk("rst_data", bus_a.out_data, 0);
        chk("rst_sec", bus_a.out_sec, 0);
        chk("rst_ded", bus_a.out_ded, 0);
        chk("rst_syn", bus_a.out_syndrome, 0);
        chk("rst_sec_count", sec_a, 0);
        chk("rst_ded_count", ded_a, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            send_dir(encode(clean_words[i]), clean_words[i], 1'b0, 1'b0, '0);
        drain();

        send_dir(CW_W'(1) << 3, 32'h0, 1'b1, 1'b0, 6'd3);
        send_dir(CW_W'(1), 32'h0, 1'b1, 1'b0, 6'd0);
        correct_en = 1'b0;
        send_dir(CW_W'(1) << 3, 32'h1, 1'b1, 1'b0, 6'd3);
        correct_en = 1'b1;
        send_dir((CW_W'(1) << 3) | (CW_W'(1) << 5), 32'h3, 1'b0, 1'b1, 6'd6);
        drain();
        chk("ded_count_after_double", ded_a, 1);

        for (int i = 0; i < 5; i++) send_dir(CW_W'(1) << 3, 32'h0, 1'b1, 1'b0, 6'd3);
        drain();
        chk("sec_sat_b", sec_b, 3);
        chk("sec_count_a_total", sec_a, 8);

        send_dir((CW_W'(1) << 3) | (CW_W'(1) << 5), 32'h3, 1'b0, 1'b1, 6'd6);
        n = 0;
        clr_counts = 1'b0;
        while (n < 10 && !clr_counts) begin
            clr_counts = bus_a.out_valid;
            cycle();
            n++;
        end
        clr_counts = 1'b0;
        chk("clr_wins_a", ded_a, 0);
        chk("clr_wins_b", ded_b, 0);
        drain();

        bp_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_cw = encode(bp_words[idx]);
            cycle();
            if (last_in_hs) idx++;
        end
        chk("bp_accepted", idx, 2);
        #1;
        chk("bp_in_ready", bus_a.in_ready, 0);
        out_ready = 1'b1;
        n = 0;
        while ((idx < 4 || exp_q.size() > 0) && n < 30) begin
            in_valid = (idx < 4);
            in_cw = encode(bp_words[idx < 4 ? idx : 3]);
            cycle();
            if (last_in_hs) idx++;
            n++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", idx, 4);
        drain();

        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 7;
            correct_en = ($urandom % 4) != 0;
            clr_counts = ($urandom % 40) == 0;
            cw = encode($urandom);
            mask = '0;
            nflip = $urandom % 4;
            for (int f = 0; f < nflip; f++) begin
                do pos = $urandom % CW_W; while (mask[pos]);
                mask[pos] = 1'b1;
            end
            in_cw = cw ^ mask;
            cycle();
        end
        clr_counts = 1'b0;
        correct_en = 1'b1;
        drain();

        send_dir(CW_W'(1) << 3, 32'h0, 1'b1, 1'b0, 6'd3);
        drain();
        send(encode($urandom));
        send(encode($urandom));
        reset = 1'b1;
        #1;
        chk("midrst_valid_a", bus_a.out_valid, 0);
        chk("midrst_valid_b", bus_b.out_valid, 0);
        chk("midrst_sec_a", sec_a, 0);
        chk("midrst_ded_b", ded_b, 0);
        exp_q.delete();
        m_sec16 = 0; m_ded16 = 0; m_sec2 = 0; m_ded2 = 0;
        stalled_prev = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        send_dir(encode(32'hDEADBEEF), 32'hDEADBEEF, 1'b0, 1'b0, '0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
